// File: rtl/irq_clint_lite.sv
// irq_clint_lite: interrupt source stage for excp_irq.
// Ext pin sync, msip, 64-bit mtime/mtimecmp, register bus.
module irq_clint_lite #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned TICK_DIV      = 1,
    parameter bit          DBG_STOP_TIME = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbg_mode,
    input  logic        ext_irq_i,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic        cmd_we,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ext_irq_r,
    output logic        sft_irq_r,
    output logic        tmr_irq_r
);

    localparam int unsigned   PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    localparam logic [15:0] A_MSIP   = 16'h0000;
    localparam logic [15:0] A_CMP_LO = 16'h4000;
    localparam logic [15:0] A_CMP_HI = 16'h4004;
    localparam logic [15:0] A_MT_LO  = 16'hBFF8;
    localparam logic [15:0] A_MT_HI  = 16'hBFFC;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   msip_q, msip_d;
    logic [63:0]            mtime_q, mtime_d;
    logic [63:0]            mtcmp_q, mtcmp_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   tmr_q;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic        hs;
    logic        wr;
    logic        hit;
    logic        tick_en;
    logic        tick;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_mt_lo;
    logic        sel_mt_hi;
    logic [31:0] rd_val;

    // Address decode; exact matches imply word alignment.
    assign sel_msip   = (cmd_addr == A_MSIP);
    assign sel_cmp_lo = (cmd_addr == A_CMP_LO);
    assign sel_cmp_hi = (cmd_addr == A_CMP_HI);
    assign sel_mt_lo  = (cmd_addr == A_MT_LO);
    assign sel_mt_hi  = (cmd_addr == A_MT_HI);
    assign hit = sel_msip | sel_cmp_lo | sel_cmp_hi
               | sel_mt_lo | sel_mt_hi;

    assign cmd_rdy = (state_q == S_IDLE) | rsp_rdy;
    assign rsp_vld = (state_q == S_RESP);
    assign hs      = cmd_vld & cmd_rdy;
    assign wr      = hs & cmd_we & hit;

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ext_irq_r = sync_q[SYNC_STAGES-1];
    assign sft_irq_r = msip_q;
    assign tmr_irq_r = tmr_q;

    assign tick_en = ~(DBG_STOP_TIME & dbg_mode);

    // Read mux over pre-update register state.
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_msip:   rd_val = {31'd0, msip_q};
            sel_cmp_lo: rd_val = mtcmp_q[31:0];
            sel_cmp_hi: rd_val = mtcmp_q[63:32];
            sel_mt_lo:  rd_val = mtime_q[31:0];
            sel_mt_hi:  rd_val = mtime_q[63:32];
            default:    rd_val = '0;
        endcase
    end

    // Bus FSM next state and response capture.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (hs) begin
            state_d = S_RESP;
            err_d   = ~hit;
            rdata_d = (cmd_we | ~hit) ? 32'd0 : rd_val;
        end else if ((state_q == S_RESP) && rsp_rdy) begin
            state_d = S_IDLE;
        end
    end

    // Prescaler: one tick every TICK_DIV enabled cycles.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (tick_en) begin
            if (presc_q == PMAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Register updates; a bus write beats the increment.
    always_comb begin
        mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;
        mtcmp_d = mtcmp_q;
        msip_d  = msip_q;
        if (wr) begin
            if (sel_mt_lo)  mtime_d = {mtime_q[63:32], cmd_wdata};
            if (sel_mt_hi)  mtime_d = {cmd_wdata, mtime_q[31:0]};
            if (sel_cmp_lo) mtcmp_d = {mtcmp_q[63:32], cmd_wdata};
            if (sel_cmp_hi) mtcmp_d = {cmd_wdata, mtcmp_q[31:0]};
            if (sel_msip)   msip_d  = cmd_wdata[0];
        end
    end

    // Bus state and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Timer, msip and registered compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= '0;
            mtcmp_q <= '1;
            presc_q <= '0;
            msip_q  <= 1'b0;
            tmr_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            mtcmp_q <= mtcmp_d;
            presc_q <= presc_d;
            msip_q  <= msip_d;
            tmr_q   <= (mtime_q >= mtcmp_q);
        end
    end

    // External pin synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_i};
        end
    end

endmodule

// File: tb/tb_irq_clint_lite.sv
// tb_irq_clint_lite: two configurations driven by one bus,
// checked every cycle against a behavioural model.
module tb_irq_clint_lite;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dbg_mode = 1'b0;
    logic        ext_irq_i = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_rdy = 1'b1;

    logic        cmd_rdy_a, rsp_vld_a, rsp_err_a;
    logic        ext_a, sft_a, tmr_a;
    logic [31:0] rdata_a;
    logic        cmd_rdy_b, rsp_vld_b, rsp_err_b;
    logic        ext_b, sft_b, tmr_b;
    logic [31:0] rdata_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irq_clint_lite u_a (
        .clk(clk), .rst_n(rst_n), .dbg_mode(dbg_mode),
        .ext_irq_i(ext_irq_i), .cmd_vld(cmd_vld),
        .cmd_rdy(cmd_rdy_a), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_vld(rsp_vld_a), .rsp_rdy(rsp_rdy),
        .rsp_rdata(rdata_a), .rsp_err(rsp_err_a),
        .ext_irq_r(ext_a), .sft_irq_r(sft_a),
        .tmr_irq_r(tmr_a)
    );

    irq_clint_lite #(
        .SYNC_STAGES(3), .TICK_DIV(4), .DBG_STOP_TIME(1'b1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .dbg_mode(dbg_mode),
        .ext_irq_i(ext_irq_i), .cmd_vld(cmd_vld),
        .cmd_rdy(cmd_rdy_b), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_vld(rsp_vld_b), .rsp_rdy(rsp_rdy),
        .rsp_rdata(rdata_b), .rsp_err(rsp_err_b),
        .ext_irq_r(ext_b), .sft_irq_r(sft_b),
        .tmr_irq_r(tmr_b)
    );

    // ---------------- behavioural model ----------------
    logic [63:0] m_mt[2];
    logic [63:0] m_cmp[2];
    logic        m_msip[2];
    logic        m_tmr[2];
    int          m_pre[2];
    logic [31:0] m_rd[2];
    logic        m_err = 1'b0;
    logic        m_rvld = 1'b0;
    logic [7:0]  m_hist = '0;

    function automatic int div_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [32:0] rd_model(int k, logic [15:0] a);
        case (a)
            16'h0000: return {1'b0, 31'd0, m_msip[k]};
            16'h4000: return {1'b0, m_cmp[k][31:0]};
            16'h4004: return {1'b0, m_cmp[k][63:32]};
            16'hBFF8: return {1'b0, m_mt[k][31:0]};
            16'hBFFC: return {1'b0, m_mt[k][63:32]};
            default:  return {1'b1, 32'd0};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        logic        hs;
        logic        bad;
        logic [32:0] r;
        logic [63:0] nt;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_mt[k] = '0;
                m_cmp[k] = '1;
                m_msip[k] = 1'b0;
                m_tmr[k] = 1'b0;
                m_pre[k] = 0;
                m_rd[k] = '0;
            end
            m_err = 1'b0;
            m_rvld = 1'b0;
            m_hist = '0;
        end else begin
            hs = cmd_vld && (!m_rvld || rsp_rdy);
            bad = (rd_model(0, cmd_addr) >> 32) != 0;
            for (int k = 0; k < 2; k++) begin
                m_tmr[k] = (m_mt[k] >= m_cmp[k]);
                if (hs) begin
                    r = rd_model(k, cmd_addr);
                    m_rd[k] = cmd_we ? 32'd0 : r[31:0];
                end
                nt = m_mt[k];
                if (!dbg_mode) begin
                    m_pre[k]++;
                    if (m_pre[k] == div_of(k)) begin
                        m_pre[k] = 0;
                        nt = m_mt[k] + 64'd1;
                    end
                end
                if (hs && cmd_we && !bad) begin
                    case (cmd_addr)
                        16'hBFF8: nt = {m_mt[k][63:32], cmd_wdata};
                        16'hBFFC: nt = {cmd_wdata, m_mt[k][31:0]};
                        16'h4000: m_cmp[k][31:0] = cmd_wdata;
                        16'h4004: m_cmp[k][63:32] = cmd_wdata;
                        16'h0000: m_msip[k] = cmd_wdata[0];
                        default: ;
                    endcase
                end
                m_mt[k] = nt;
            end
            if (hs) begin
                m_err = bad;
                m_rvld = 1'b1;
            end else if (rsp_rdy) begin
                m_rvld = 1'b0;
            end
            m_hist = {m_hist[6:0], ext_irq_i};
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("cmd_rdy_a", cmd_rdy_a, !m_rvld || rsp_rdy);
        chk("cmd_rdy_b", cmd_rdy_b, !m_rvld || rsp_rdy);
        chk("rsp_vld_a", rsp_vld_a, m_rvld);
        chk("rsp_vld_b", rsp_vld_b, m_rvld);
        if (m_rvld) begin
            chk("rdata_a", rdata_a, m_rd[0]);
            chk("rdata_b", rdata_b, m_rd[1]);
            chk("err_a", rsp_err_a, m_err);
            chk("err_b", rsp_err_b, m_err);
        end
        chk("ext_a", ext_a, m_hist[1]);
        chk("ext_b", ext_b, m_hist[2]);
        chk("sft_a", sft_a, m_msip[0]);
        chk("sft_b", sft_b, m_msip[1]);
        chk("tmr_a", tmr_a, m_tmr[0]);
        chk("tmr_b", tmr_b, m_tmr[1]);
    end

    // ---------------- directed helpers ----------------
    // Called #1 after an edge; returns #1 after the handshake edge.
    task automatic bus(input logic we, input logic [15:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic er, output logic [31:0] rdb);
        cmd_vld = 1'b1;
        cmd_we = we;
        cmd_addr = a;
        cmd_wdata = d;
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        chk("bus_rsp_vld", rsp_vld_a, 1);
        rd = rdata_a;
        er = rsp_err_a;
        rdb = rdata_b;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd, rdb;
    logic        er;
    logic [31:0] w;

    initial begin
        step(3);
        rst_n = 1'b1;

        // reset state
        step(10);
        chk("rst_ext", ext_a, 0);
        chk("rst_sft", sft_a, 0);
        chk("rst_tmr", tmr_a, 0);
        chk("rst_rsp_vld", rsp_vld_a, 0);
        chk("rst_rdata", rdata_a, 0);
        bus(0, 16'h4004, 0, rd, er, rdb);
        chk("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        chk("rst_cmp_hi_err", er, 0);

        // ext level and one-cycle pulse
        ext_irq_i = 1'b1;
        step(1);
        chk("ext_n1", ext_a, 0);
        step(1);
        chk("ext_n2", ext_a, 1);
        ext_irq_i = 1'b0;
        step(3);
        ext_irq_i = 1'b1;
        step(1);
        ext_irq_i = 1'b0;
        step(1);
        chk("ext_pulse_hi", ext_a, 1);
        step(1);
        chk("ext_pulse_lo", ext_a, 0);

        // msip
        bus(1, 16'h0000, 32'h1, rd, er, rdb);
        chk("msip_set", sft_a, 1);
        bus(0, 16'h0000, 0, rd, er, rdb);
        chk("msip_rd1", rd, 32'h1);
        bus(1, 16'h0000, 32'hFFFF_FFFE, rd, er, rdb);
        chk("msip_clr", sft_a, 0);
        bus(0, 16'h0000, 0, rd, er, rdb);
        chk("msip_rd0", rd, 32'h0);

        // timer compare
        bus(1, 16'h4004, 32'd0, rd, er, rdb);
        bus(1, 16'h4000, 32'd20, rd, er, rdb);
        bus(1, 16'hBFF8, 32'd0, rd, er, rdb);
        for (int k = 1; k <= 21; k++) begin
            step(1);
            if (k == 20) chk("tmr_at20", tmr_a, 0);
            if (k == 21) chk("tmr_at21", tmr_a, 1);
        end
        bus(1, 16'h4000, 32'hFFFF_FFFF, rd, er, rdb);
        chk("tmr_hold", tmr_a, 1);
        step(1);
        chk("tmr_fall", tmr_a, 0);

        // carry and wrap
        dbg_mode = 1'b1;
        bus(1, 16'hBFF8, 32'hFFFF_FFFE, rd, er, rdb);
        bus(1, 16'hBFFC, 32'h0, rd, er, rdb);
        bus(0, 16'hBFF8, 0, rd, er, rdb);
        chk("carry_pre", rd, 32'hFFFF_FFFE);
        dbg_mode = 1'b0;
        step(2);
        dbg_mode = 1'b1;
        bus(0, 16'hBFF8, 0, rd, er, rdb);
        chk("carry_lo", rd, 32'h0);
        bus(0, 16'hBFFC, 0, rd, er, rdb);
        chk("carry_hi", rd, 32'h1);
        bus(1, 16'hBFF8, 32'hFFFF_FFFF, rd, er, rdb);
        bus(1, 16'hBFFC, 32'hFFFF_FFFF, rd, er, rdb);
        dbg_mode = 1'b0;
        step(1);
        dbg_mode = 1'b1;
        bus(0, 16'hBFF8, 0, rd, er, rdb);
        chk("wrap_lo", rd, 32'h0);
        bus(0, 16'hBFFC, 0, rd, er, rdb);
        chk("wrap_hi", rd, 32'h0);

        // errors and back-pressure
        bus(0, 16'h0002, 0, rd, er, rdb);
        chk("mis_err", er, 1);
        chk("mis_rdata", rd, 0);
        bus(0, 16'h1234, 0, rd, er, rdb);
        chk("unm_err", er, 1);
        step(1);
        cmd_vld = 1'b1;
        cmd_we = 1'b0;
        cmd_addr = 16'h0002;
        rsp_rdy = 1'b0;
        step(1);
        cmd_addr = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_vld", rsp_vld_a, 1);
            chk("bp_err", rsp_err_a, 1);
            chk("bp_rdata", rdata_a, 0);
            chk("bp_cmd_rdy", cmd_rdy_a, 0);
        end
        rsp_rdy = 1'b1;
        step(1);
        cmd_vld = 1'b0;
        chk("bp_next_vld", rsp_vld_a, 1);
        chk("bp_next_err", rsp_err_a, 0);
        chk("bp_next_rdata", rdata_a, 32'hFFFF_FFFF);
        step(1);
        chk("bp_done", rsp_vld_a, 0);

        // debug freeze and divided tick
        bus(1, 16'hBFF8, 32'h1234_5678, rd, er, rdb);
        step(100);
        bus(0, 16'hBFF8, 0, rd, er, rdb);
        chk("dbg_frozen", rd, 32'h1234_5678);
        bus(1, 16'hBFF8, 32'h0, rd, er, rdb);
        dbg_mode = 1'b0;
        step(40);
        dbg_mode = 1'b1;
        bus(0, 16'hBFF8, 0, rd, er, rdb);
        chk("div1_count", rd, 32'd40);
        chk("div4_count", rdb, 32'd10);
        dbg_mode = 1'b0;

        // randomized traffic with one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
            cmd_vld = ($urandom_range(0, 1) == 1);
            cmd_we = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 8))
                0: cmd_addr = 16'h0000;
                1: cmd_addr = 16'h4000;
                2: cmd_addr = 16'h4004;
                3: cmd_addr = 16'hBFF8;
                4: cmd_addr = 16'hBFFC;
                5: cmd_addr = 16'h0002;
                6: cmd_addr = 16'h1234;
                7: cmd_addr = 16'h4001;
                default: cmd_addr = 16'hBFFD;
            endcase
            case ($urandom_range(0, 3))
                0, 1: w = $urandom_range(0, 40);
                2: w = $urandom;
                default: w = 32'hFFFF_FFFF - $urandom_range(0, 3);
            endcase
            cmd_wdata = w;
            rsp_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) ext_irq_i = ~ext_irq_i;
            dbg_mode = ($urandom_range(0, 9) == 0);
            step(1);
        end
        cmd_vld = 1'b0;
        rsp_rdy = 1'b1;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
